// File: rtl/lbp_engine.sv
// Raster-scan local-binary-pattern engine with a column-reusing 3x3 window.
// Fetches gray pixels from a combinational memory port and writes one 8-bit code per pixel.
module lbp_engine #(
  parameter int unsigned IMG_W = 128,
  parameter int unsigned IMG_H = 128,
  parameter int unsigned DW    = 8,
  parameter int unsigned AW    = 14
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          gray_ready_i,
  input  logic [DW-1:0] gray_data_i,
  input  logic          cmp_mode_i,
  input  logic          border_en_i,
  output logic          gray_req_o,
  output logic [AW-1:0] gray_addr_o,
  output logic          lbp_valid_o,
  output logic [AW-1:0] lbp_addr_o,
  output logic [7:0]    lbp_data_o,
  output logic          finish_o
);

  localparam int unsigned RW = $clog2(IMG_H);
  localparam int unsigned CW = $clog2(IMG_W);

  typedef enum logic [3:0] {
    StIdle, StBTop, StRowInit, StBLeft, StEmit, StColFetch, StBRight, StNextRow, StBBot, StDone
  } state_e;

  state_e                      state_q;
  logic [RW-1:0]               row_q;
  logic [CW-1:0]               col_q;
  logic [3:0]                  fidx_q;
  logic                        cmp_q;
  logic                        bord_q;
  logic [2:0][2:0][DW-1:0]     win_q;
  logic [2:0][2:0][DW-1:0]     win_d;

  logic                        gray_req_q;
  logic [AW-1:0]               gray_addr_q;
  logic                        lbp_valid_q;
  logic [AW-1:0]               lbp_addr_q;
  logic [7:0]                  lbp_data_q;
  logic                        finish_q;

  logic [3:0]                  fidx_nx;
  logic [1:0]                  init_r;
  logic [1:0]                  init_c;
  logic                        last_col;
  logic [7:0][DW-1:0]          nbr;
  logic [DW-1:0]               cen;
  logic [7:0]                  lbp_code;

  function automatic logic [AW-1:0] pix_addr(input int unsigned r, input int unsigned c);
    return AW'(r * IMG_W + c);
  endfunction

  assign fidx_nx  = fidx_q + 4'd1;
  assign init_r   = 2'(fidx_q % 4'd3);
  assign init_c   = 2'(fidx_q / 4'd3);
  assign last_col = 32'(col_q) >= IMG_W - 2;

  // Window as it will look after this edge; the code written on entry to EMIT needs the
  // pixel being captured on that same edge.
  always_comb begin
    win_d = win_q;
    case (state_q)
      StRowInit:  win_d[init_r][init_c] = gray_data_i;
      StColFetch: win_d[fidx_q[1:0]][2] = gray_data_i;
      StEmit: begin
        if (!last_col) begin
          for (int r = 0; r < 3; r++) begin
            win_d[r][0] = win_q[r][1];
            win_d[r][1] = win_q[r][2];
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    cen      = win_d[1][1];
    nbr      = {win_d[2][2], win_d[2][1], win_d[2][0], win_d[1][2],
                win_d[1][0], win_d[0][2], win_d[0][1], win_d[0][0]};
    lbp_code = '0;
    for (int k = 0; k < 8; k++) begin
      lbp_code[k] = cmp_q ? (nbr[k] > cen) : (nbr[k] >= cen);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      row_q       <= '0;
      col_q       <= '0;
      fidx_q      <= '0;
      cmp_q       <= 1'b0;
      bord_q      <= 1'b0;
      win_q       <= '0;
      gray_req_q  <= 1'b0;
      gray_addr_q <= '0;
      lbp_valid_q <= 1'b0;
      lbp_addr_q  <= '0;
      lbp_data_q  <= '0;
      finish_q    <= 1'b0;
    end else if (gray_ready_i) begin
      win_q       <= win_d;
      gray_req_q  <= 1'b0;
      lbp_valid_q <= 1'b0;
      lbp_data_q  <= '0;
      case (state_q)
        StIdle: begin
          cmp_q  <= cmp_mode_i;
          bord_q <= border_en_i;
          if (border_en_i) begin
            state_q     <= StBTop;
            row_q       <= '0;
            col_q       <= '0;
            lbp_valid_q <= 1'b1;
            lbp_addr_q  <= '0;
          end else begin
            state_q     <= StRowInit;
            row_q       <= RW'(1);
            col_q       <= CW'(1);
            fidx_q      <= '0;
            gray_req_q  <= 1'b1;
            gray_addr_q <= '0;
          end
        end
        StBTop: begin
          if (32'(col_q) == IMG_W - 1) begin
            state_q     <= StRowInit;
            row_q       <= RW'(1);
            col_q       <= CW'(1);
            fidx_q      <= '0;
            gray_req_q  <= 1'b1;
            gray_addr_q <= '0;
          end else begin
            col_q       <= col_q + CW'(1);
            lbp_valid_q <= 1'b1;
            lbp_addr_q  <= pix_addr(0, 32'(col_q) + 1);
          end
        end
        StRowInit: begin
          if (fidx_q == 4'd8) begin
            lbp_valid_q <= 1'b1;
            if (bord_q) begin
              state_q    <= StBLeft;
              lbp_addr_q <= pix_addr(32'(row_q), 0);
            end else begin
              state_q    <= StEmit;
              lbp_addr_q <= pix_addr(32'(row_q), 32'(col_q));
              lbp_data_q <= lbp_code;
            end
          end else begin
            fidx_q      <= fidx_nx;
            gray_req_q  <= 1'b1;
            gray_addr_q <= pix_addr(32'(row_q) - 1 + 32'(fidx_nx) % 3,
                                    32'(col_q) - 1 + 32'(fidx_nx) / 3);
          end
        end
        StBLeft: begin
          state_q     <= StEmit;
          lbp_valid_q <= 1'b1;
          lbp_addr_q  <= pix_addr(32'(row_q), 32'(col_q));
          lbp_data_q  <= lbp_code;
        end
        StEmit: begin
          if (!last_col) begin
            state_q     <= StColFetch;
            col_q       <= col_q + CW'(1);
            fidx_q      <= '0;
            gray_req_q  <= 1'b1;
            gray_addr_q <= pix_addr(32'(row_q) - 1, 32'(col_q) + 2);
          end else if (bord_q) begin
            state_q     <= StBRight;
            lbp_valid_q <= 1'b1;
            lbp_addr_q  <= pix_addr(32'(row_q), IMG_W - 1);
          end else begin
            // Without border rows this was the final write; raise finish right behind it.
            state_q  <= StNextRow;
            finish_q <= (32'(row_q) == IMG_H - 2);
          end
        end
        StColFetch: begin
          if (fidx_q == 4'd2) begin
            state_q     <= StEmit;
            lbp_valid_q <= 1'b1;
            lbp_addr_q  <= pix_addr(32'(row_q), 32'(col_q));
            lbp_data_q  <= lbp_code;
          end else begin
            fidx_q      <= fidx_nx;
            gray_req_q  <= 1'b1;
            gray_addr_q <= pix_addr(32'(row_q) - 1 + 32'(fidx_nx), 32'(col_q) + 1);
          end
        end
        StBRight: state_q <= StNextRow;
        StNextRow: begin
          if (32'(row_q) + 1 <= IMG_H - 2) begin
            state_q     <= StRowInit;
            row_q       <= row_q + RW'(1);
            col_q       <= CW'(1);
            fidx_q      <= '0;
            gray_req_q  <= 1'b1;
            gray_addr_q <= pix_addr(32'(row_q), 0);
          end else if (bord_q) begin
            state_q     <= StBBot;
            row_q       <= RW'(IMG_H - 1);
            col_q       <= '0;
            lbp_valid_q <= 1'b1;
            lbp_addr_q  <= pix_addr(IMG_H - 1, 0);
          end else begin
            state_q  <= StDone;
            finish_q <= 1'b1;
          end
        end
        StBBot: begin
          if (32'(col_q) == IMG_W - 1) begin
            state_q  <= StDone;
            finish_q <= 1'b1;
          end else begin
            col_q       <= col_q + CW'(1);
            lbp_valid_q <= 1'b1;
            lbp_addr_q  <= pix_addr(IMG_H - 1, 32'(col_q) + 1);
          end
        end
        StDone:  state_q <= StDone;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign gray_req_o  = gray_req_q;
  assign gray_addr_o = gray_addr_q;
  assign lbp_valid_o = lbp_valid_q;
  assign lbp_addr_o  = lbp_addr_q;
  assign lbp_data_o  = lbp_data_q;
  assign finish_o    = finish_q;

endmodule
